// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_SRC FWFT FIFO read ports into one valid/ready stream.
// Each grant pops up to a clamped burst of words from a single source, then rotates.
module fifo_drain_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned SRC_W      = $clog2(NUM_SRC),
    parameter int unsigned BL_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [BL_W-1:0]               burst_len,
    input  logic [NUM_SRC-1:0]            src_empty,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rd_data,
    output logic [NUM_SRC-1:0]            src_rd_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_last,
    output logic                          busy
);

    localparam int unsigned IDX_W = SRC_W + 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                state_q, state_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]      gnt_q, gnt_d, gnt_inc;
    logic [BL_W-1:0]       remaining_q, remaining_d, burst_clamped;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q, gnt_data;
    logic [SRC_W-1:0]      out_src_q;
    logic                  out_last_q;
    logic                  can_load, pop, found;
    logic [SRC_W-1:0]      rr_pick;
    logic [IDX_W-1:0]      idx;

    always_comb begin
        if (burst_len == '0) begin
            burst_clamped = BL_W'(1);
        end else if (burst_len > BL_W'(MAX_BURST)) begin
            burst_clamped = BL_W'(MAX_BURST);
        end else begin
            burst_clamped = burst_len;
        end
    end

    // First non-empty source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        rr_pick = rr_ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_SRC)) begin
                idx = idx - IDX_W'(NUM_SRC);
            end
            if (!found && !src_empty[idx[SRC_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[SRC_W-1:0];
            end
        end
    end

    assign gnt_inc  = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + SRC_W'(1);
    assign gnt_data = src_rd_data[int'(gnt_q) * DATA_WIDTH +: DATA_WIDTH];
    assign can_load = !out_valid_q || out_ready;
    assign pop      = (state_q == StBurst) && !src_empty[gnt_q] && can_load;

    always_comb begin
        src_rd_en = '0;
        if (pop) begin
            src_rd_en[gnt_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        remaining_d = remaining_q;
        case (state_q)
            StIdle: begin
                if (enable && found) begin
                    gnt_d       = rr_pick;
                    remaining_d = burst_clamped;
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                // Empty is only acted on when a word could have been taken.
                if (can_load) begin
                    if (src_empty[gnt_q]) begin
                        state_d     = StIdle;
                        rr_ptr_d    = gnt_inc;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - BL_W'(1);
                        if (remaining_q == BL_W'(1)) begin
                            state_d  = StIdle;
                            rr_ptr_d = gnt_inc;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            remaining_q <= remaining_d;
            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= gnt_data;
                out_src_q   <= gnt_q;
                out_last_q  <= (remaining_q == BL_W'(1));
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == StBurst) || out_valid_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FWFT source models, directed stimulus pushing
// expected words into a scoreboard, and a negedge monitor that checks them.
module tb_fifo_drain_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DW      = 32;
    localparam int BL_W    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [BL_W-1:0]       burst_len;
    logic [NUM_SRC-1:0]    src_empty;
    logic [NUM_SRC*DW-1:0] src_rd_data;
    logic [NUM_SRC-1:0]    src_rd_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [1:0]            out_src;
    logic                  out_last;
    logic                  busy;

    fifo_drain_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DW),
        .MAX_BURST  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .burst_len   (burst_len),
        .src_empty   (src_empty),
        .src_rd_data (src_rd_data),
        .src_rd_en   (src_rd_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // FWFT source models
    logic [DW-1:0] mem [NUM_SRC][256];
    int            head [NUM_SRC];
    int            tail [NUM_SRC];
    logic          flush;
    int            cyc = 0;

    always_comb begin
        src_empty   = '0;
        src_rd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_empty[i]          = (head[i] == tail[i]);
            src_rd_data[i*DW +: DW] = mem[i][head[i] % 256];
        end
    end

    initial begin
        for (int i = 0; i < NUM_SRC; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush) head[i] <= tail[i];
                else if (src_rd_en[i]) head[i] <= head[i] + 1;
            end
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    src;
        logic          last;
        int            gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   deadline = -1;

    task automatic chk(input string name, input bit ok, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, got, want);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, pop legality, drain deadlines.
    initial begin
        exp_t          e;
        int            last_acc = 0;
        bit            hold_vld = 0;
        logic [DW-1:0] hold_data = '0;
        logic [1:0]    hold_src = '0;
        logic          hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs",
                    out_valid === 1'b0 && busy === 1'b0 && src_rd_en === '0 &&
                    out_data === '0 && out_src === '0 && out_last === 1'b0,
                    $sformatf("valid=%b busy=%b rd_en=%b data=%h src=%0d last=%b",
                              out_valid, busy, src_rd_en, out_data, out_src, out_last),
                    "all zero");
                hold_vld = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1'b0,
                            $sformatf("data=%h src=%0d", out_data, out_src), "no word");
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", out_data === e.data && out_src === e.src && out_last === e.last,
                            $sformatf("data=%h src=%0d last=%b", out_data, out_src, out_last),
                            $sformatf("data=%h src=%0d last=%b", e.data, e.src, e.last));
                        if (e.gap >= 0) begin
                            chk("gap", (cyc - last_acc) == e.gap,
                                $sformatf("%0d", cyc - last_acc), $sformatf("%0d", e.gap));
                        end
                    end
                    last_acc = cyc;
                end
                if (hold_vld) begin
                    chk("stall_hold", out_valid === 1'b1 && out_data === hold_data &&
                        out_src === hold_src && out_last === hold_last,
                        $sformatf("valid=%b data=%h src=%0d", out_valid, out_data, out_src),
                        $sformatf("valid=1 data=%h src=%0d", hold_data, hold_src));
                end
                hold_vld = 0;
                if (out_valid && !out_ready) begin
                    chk("stall_rd_en", src_rd_en === '0, $sformatf("%b", src_rd_en), "0000");
                    hold_vld  = 1;
                    hold_data = out_data;
                    hold_src  = out_src;
                    hold_last = out_last;
                end
                if (src_rd_en !== '0) begin
                    chk("rd_en_legal", $onehot(src_rd_en) && (src_rd_en & src_empty) == '0,
                        $sformatf("rd_en=%b empty=%b", src_rd_en, src_empty),
                        "one-hot pop of a non-empty source");
                end
                if (cyc == deadline) begin
                    chk("drained", exp_q.size() == 0 && busy === 1'b0,
                        $sformatf("left=%0d busy=%b", exp_q.size(), busy), "left=0 busy=0");
                end
            end
        end
    end

    task automatic load(input int s, input logic [DW-1:0] d);
        mem[s][tail[s] % 256] = d;
        tail[s] = tail[s] + 1;
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input int s, input bit last, input int gap);
        exp_t e;
        e.data = d;
        e.src  = 2'(s);
        e.last = last;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int n);
        deadline = cyc + n;
        repeat (n + 1) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit pat [4];
        int pops;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst_n     = 1'b1;
        enable    = 1'b0;
        burst_len = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        #1;
        do_reset();

        // Single source, two 4-word bursts.
        burst_len = 4'd4;
        for (int j = 0; j < 8; j++) begin
            load(0, 32'h10 + j);
            expect_word(32'h10 + j, 0, (j % 4) == 3, j == 0 ? -1 : (j == 4 ? 2 : 1));
        end
        enable = 1'b1;
        wait_done(40);

        // Round robin, burst of 2 across four full sources.
        do_reset();
        burst_len = 4'd2;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 8; j++) load(s, 32'hA000_0000 | (s << 8) | j);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 2; w++)
                    expect_word(32'hA000_0000 | (s << 8) | (2 * r + w), s, w == 1,
                                (r == 0 && s == 0 && w == 0) ? -1 : (w == 0 ? 2 : 1));
        enable = 1'b1;
        wait_done(100);

        // Truncated burst on src1, full burst on src2.
        do_reset();
        burst_len = 4'd4;
        for (int j = 0; j < 3; j++) begin
            load(1, 32'h3100 + j);
            expect_word(32'h3100 + j, 1, 1'b0, j == 0 ? -1 : 1);
        end
        for (int j = 0; j < 4; j++) begin
            load(2, 32'h3200 + j);
            expect_word(32'h3200 + j, 2, j == 3, j == 0 ? -1 : 1);
        end
        enable = 1'b1;
        wait_done(30);

        // Backpressure with out_ready 1,0,0,1.
        do_reset();
        burst_len = 4'd8;
        for (int j = 0; j < 8; j++) begin
            load(0, 32'h4400 + j);
            expect_word(32'h4400 + j, 0, j == 7, -1);
        end
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            out_ready = pat[k % 4];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_done(20);

        // burst_len 0 acts as 1.
        do_reset();
        burst_len = 4'd0;
        load(0, 32'h5000); load(0, 32'h5001);
        load(1, 32'h5100); load(1, 32'h5101);
        expect_word(32'h5000, 0, 1'b1, -1);
        expect_word(32'h5100, 1, 1'b1, 2);
        expect_word(32'h5001, 0, 1'b1, 2);
        expect_word(32'h5101, 1, 1'b1, 2);
        enable = 1'b1;
        wait_done(30);

        // burst_len 15 clamps to 8.
        do_reset();
        burst_len = 4'd15;
        for (int j = 0; j < 10; j++) begin
            load(3, 32'h5F00 + j);
            expect_word(32'h5F00 + j, 3, j == 7, j == 0 ? -1 : (j == 8 ? 2 : 1));
        end
        enable = 1'b1;
        wait_done(40);

        // enable dropped at the 2nd pop: burst completes, no new grant.
        do_reset();
        burst_len = 4'd4;
        for (int j = 0; j < 8; j++) load(0, 32'h6000 + j);
        for (int j = 0; j < 4; j++) expect_word(32'h6000 + j, 0, j == 3, j == 0 ? -1 : 1);
        enable = 1'b1;
        pops   = 0;
        for (int k = 0; k < 20 && pops < 2; k++) begin
            @(negedge clk);
            if (src_rd_en[0]) pops++;
        end
        enable = 1'b0;
        wait_done(12);

        // Reset with a popped word still held by backpressure; it is discarded.
        out_ready = 1'b0;
        enable    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        do_reset();
        out_ready = 1'b1;
        wait_done(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Single-clock round-robin scheduler that drains NUM_SRC first-word-fall-through FIFO read ports into one valid/ready output stream.
- Sits on the read side of a bank of async_fifo_asymm_concat_fwft / async_fifo_asymm_split_fwft instances, all read on a common clock.
- Grants one source at a time for a configurable burst of words, then rotates. Each output word carries its source index.

Parameters:
- NUM_SRC, 4, number of FWFT FIFO read ports (2..16)
- DATA_WIDTH, 32, width of each source rd_data and of out_data
- MAX_BURST, 8, maximum words per grant; burst_len is clamped to this value
- SRC_W, $clog2(NUM_SRC), derived, width of source index
- BL_W, $clog2(MAX_BURST+1), derived, width of burst_len

Ports:
- clk  input  1  single clock for FIFO read side and output
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  allows new grants; an in-progress burst always completes
- burst_len  input  BL_W  words per grant; sampled at grant time; 0 is treated as 1; values above MAX_BURST use MAX_BURST
- src_empty  input  NUM_SRC  per-source FIFO empty
- src_rd_data  input  NUM_SRC*DATA_WIDTH  per-source FWFT head data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_rd_en  output  NUM_SRC  per-source pop, one-hot or zero
- out_valid  output  1  out_data/out_src/out_last are valid
- out_ready  input  1  downstream accepts the current word
- out_data  output  DATA_WIDTH  drained word
- out_src  output  SRC_W  index of the source that supplied out_data
- out_last  output  1  word completes a full-length burst
- busy  output  1  state is BURST or out_valid is high

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, gnt=0, remaining=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0, src_rd_en=0.
- FWFT contract: src_rd_data[i] is valid whenever !src_empty[i]. A pop is src_rd_en[i]=1 for one cycle.
- src_rd_en is combinational from the registered state plus out_ready. It never asserts while src_empty is high.
- Output stage is a single register:
  - can_load = !out_valid || out_ready.
  - On a pop, out_data/out_src/out_last load at the next edge and out_valid=1.
  - If out_valid && out_ready with no pop, out_valid clears at the next edge.
  - While out_valid && !out_ready, all outputs are held stable.
- FSM IDLE:
  - If enable=1 and any src_empty bit is 0, gnt = first non-empty index searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - Load remaining from clamped burst_len and go to BURST.
  - No pop occurs in the IDLE cycle, so grant latency is one cycle.
- FSM BURST:
  - pop = !src_empty[gnt] && can_load; src_rd_en[gnt] = pop.
  - On pop: remaining decrements; out_last loads (remaining==1).
  - Full burst: if remaining==1 on the pop, go to IDLE and set rr_ptr = (gnt+1) mod NUM_SRC.
  - Truncated burst: if src_empty[gnt]=1 while can_load=1, go to IDLE with rr_ptr = (gnt+1) mod NUM_SRC, and no word is marked last.
  - Backpressure: while can_load=0 the FSM waits in BURST and the empty state is ignored.
- Throughput: one word per clock while out_ready=1 and the granted source stays non-empty. One idle cycle between bursts.
- Fairness: a source that stays non-empty is granted at least once every NUM_SRC grants.
- enable deassert mid-burst: the burst runs to completion or truncation, then the FSM stays in IDLE. An undrained out_valid word is still delivered.
- burst_len changes mid-burst have no effect until the next grant.
- Reset mid-burst: everything returns to reset values immediately. A word already popped but not accepted is discarded, and upstream FIFOs must be reset together.
- Simultaneous source becoming non-empty and burst end: the source is eligible in the next IDLE cycle.

Test Plan:
1. Single source: NUM_SRC=4, burst_len=4; src0 holds 0x10..0x17; out_ready=1.
   Required: words 0x10..0x17 in order, out_src=0, out_last on 0x13 and 0x17, one gap cycle between the two bursts.
2. Round robin: all 4 sources hold 8 words, burst_len=2.
   Required: out_src sequence 0,0,1,1,2,2,3,3,0,0,...; 32 words total; out_last on every 2nd word.
3. Truncation: src1 holds 3 words, src2 holds 4; burst_len=4.
   Required: three src1 words with no out_last, then four src2 words with out_last on the 4th.
4. Backpressure: out_ready toggles 1,0,0,1 repeatedly during a burst.
   Required: out_data/out_src stable while stalled, src_rd_en=0 during stall cycles, no loss or duplication (compare against the source sequence).
5. burst_len=0 and burst_len=15 with MAX_BURST=8.
   Required: 1 word per grant with out_last on each; 8 words per grant respectively.
6. enable dropped at the 2nd word of a 4-word burst, then rst_n pulsed low mid-burst.
   Required: the burst finishes 4 words and no new grant is made; on reset, out_valid=0, busy=0 and src_rd_en=0 asynchronously.
